// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags. Read data is registered (1-cycle latency).
module sync_fifo #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_empty;
  logic             is_full;
  logic             wr_accept;
  logic             rd_accept;

  // Status is a pure function of the registered count, so no enable reaches an output.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (32'(count_q) == DEPTH);
  end

  // A full FIFO still accepts a write when a read frees the oldest slot that cycle.
  always_comb begin
    wr_accept = wr_en && (!is_full || rd_en);
    rd_accept = rd_en && !is_empty;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q  | (wr_en && is_full && !rd_en);
    underflow_d = underflow_q | (rd_en && is_empty);

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left uninitialised by reset; reset only blocks a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  always_comb begin
    dataOut      = dout_q;
    count        = count_q;
    empty        = is_empty;
    full         = is_full;
    almost_full  = (32'(count_q) >= AF_LEVEL);
    almost_empty = (32'(count_q) <= AE_LEVEL);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=4, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] dataIn;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] dataOut;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] q[$];
  logic [3:0] exp_dout;

  sync_fifo #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .wr_en(wr_en), .rd_en(rd_en),
    .dataOut(dataOut), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then sample 1ns after the edge.
  task automatic op(input logic w, input logic r, input logic [3:0] d);
    wr_en  = w;
    rd_en  = r;
    dataIn = d;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; dataIn = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    n_checks++; if (dataOut !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dataOut); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_errs: got ov=%b un=%b expected 0 0", overflow, underflow); end
    n_checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost: got ae=%b af=%b expected 1 0", almost_empty, almost_full); end
  endtask

  task automatic test_order();
    logic [3:0] vals [4];
    vals = '{4'h3, 4'h7, 4'hA, 4'hC};
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, vals[i]);
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL order_count_full: got %0d expected 4", count); end
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, 4'h0);
      n_checks++; if (dataOut !== vals[i]) begin n_fail++; $display("FAIL order_dout[%0d]: got %h expected %h", i, dataOut, vals[i]); end
      n_checks++; if (count !== 4'(3 - i)) begin n_fail++; $display("FAIL order_count[%0d]: got %0d expected %0d", i, count, 3 - i); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL order_empty: got %b expected 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 4'(i));
    n_checks++; if (full !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL ovf_full: got full=%b count=%0d expected 1 8", full, count); end
    n_checks++; if (almost_full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got af=%b ov=%b expected 1 0", almost_full, overflow); end
    op(1'b1, 1'b0, 4'hF);
    n_checks++; if (overflow !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL ovf_set: got ov=%b count=%0d expected 1 8", overflow, count); end
    for (int i = 1; i <= 8; i++) begin
      op(1'b0, 1'b1, 4'h0);
      n_checks++; if (dataOut !== 4'(i)) begin n_fail++; $display("FAIL ovf_dout[%0d]: got %h expected %h", i, dataOut, 4'(i)); end
    end
    n_checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: got empty=%b ov=%b expected 1 1", empty, overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 4'(i));
    op(1'b1, 1'b1, 4'h9);
    n_checks++; if (dataOut !== 4'h1) begin n_fail++; $display("FAIL fullrw_dout: got %h expected 1", dataOut); end
    n_checks++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL fullrw_count: got count=%0d full=%b expected 8 1", count, full); end
    for (int i = 2; i <= 9; i++) begin
      op(1'b0, 1'b1, 4'h0);
      n_checks++; if (dataOut !== 4'(i)) begin n_fail++; $display("FAIL fullrw_dout[%0d]: got %h expected %h", i, dataOut, 4'(i)); end
    end
    n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL fullrw_empty: got empty=%b count=%0d expected 1 0", empty, count); end
  endtask

  task automatic test_underflow();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_pre: got %b expected 0", underflow); end
    op(1'b1, 1'b1, 4'h5);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got %b expected 1", underflow); end
    n_checks++; if (dataOut !== 4'h9) begin n_fail++; $display("FAIL unf_dout_hold: got %h expected 9", dataOut); end
    n_checks++; if (count !== 4'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL unf_count: got count=%0d empty=%b expected 1 0", count, empty); end
    op(1'b0, 1'b1, 4'h0);
    n_checks++; if (dataOut !== 4'h5 || count !== 4'd0) begin n_fail++; $display("FAIL unf_next: got dout=%h count=%0d expected 5 0", dataOut, count); end
  endtask

  // Queue model of arrival order; checks every visible output after each cycle.
  task automatic model_op(input logic w, input logic r, input logic [3:0] d);
    logic wa, ra;
    wa = w && ((q.size() != 8) || r);
    ra = r && (q.size() != 0);
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    op(w, r, d);
    n_checks++; if (dataOut !== exp_dout) begin n_fail++; $display("FAIL wrap_dout: got %h expected %h", dataOut, exp_dout); end
    n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", count, q.size()); end
    n_checks++; if (almost_full !== (q.size() >= 6) || almost_empty !== (q.size() <= 2)) begin
      n_fail++; $display("FAIL wrap_almost: got af=%b ae=%b expected %b %b (count %0d)", almost_full, almost_empty, q.size() >= 6, q.size() <= 2, q.size());
    end
  endtask

  task automatic test_wrap_and_reset();
    q.delete();
    exp_dout = 4'h5;
    for (int i = 0; i < 6; i++) model_op(1'b1, 1'b0, 4'(i + 10));
    n_checks++; if (almost_full !== 1'b1 || count !== 4'd6) begin n_fail++; $display("FAIL wrap_af6: got af=%b count=%0d expected 1 6", almost_full, count); end
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0: model_op(1'b1, 1'b0, 4'(i * 3 + 1));
        1: model_op(1'b0, 1'b1, 4'h0);
        2: model_op(1'b1, 1'b1, 4'(i * 3 + 1));
        default: model_op(1'b0, 1'b1, 4'h0);
      endcase
    end
    n_checks++; if (count !== 4'd1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end: got count=%0d ae=%b expected 1 1", count, almost_empty); end
    for (int i = 0; i < 4; i++) model_op(1'b1, 1'b0, 4'(i + 4'hB));
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 5", count); end
    rst = 1'b0;
    op(1'b1, 1'b1, 4'hE);
    rst = 1'b1;
    q.delete();
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL midrst_status: got count=%0d empty=%b full=%b expected 0 1 0", count, empty, full); end
    n_checks++; if (dataOut !== 4'h0) begin n_fail++; $display("FAIL midrst_dout: got %h expected 0", dataOut); end
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL midrst_errs: got ov=%b un=%b expected 0 0", overflow, underflow); end
    n_checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL midrst_almost: got ae=%b af=%b expected 1 0", almost_empty, almost_full); end
    op(1'b0, 1'b1, 4'h0);
    n_checks++; if (underflow !== 1'b1 || dataOut !== 4'h0 || count !== 4'd0) begin
      n_fail++; $display("FAIL postrst_read: got un=%b dout=%h count=%0d expected 1 0 0", underflow, dataOut, count);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
